// File: rtl/guess_decoder_pkg.sv
// Shared definitions for the guess decoder.
//
// Purpose: charset codes, charset sizes, the first/last characters of each
// character range, the guess-length decode and the decoder state encoding.
// The ranges here must stay identical to the ones used by the forward
// guess generator, otherwise decoded positions will not round-trip.
package guess_decoder_pkg;

    // Charset codes carried on the charset input.
    localparam logic [2:0] CS_LOWER = 3'd0;  // 'a'..'z'
    localparam logic [2:0] CS_UPPER = 3'd1;  // 'A'..'Z'
    localparam logic [2:0] CS_ALPHA = 3'd2;  // 'a'..'z' then 'A'..'Z'
    localparam logic [2:0] CS_ALNUM = 3'd3;  // as CS_ALPHA then '0'..'9'
    localparam logic [2:0] CS_PRINT = 3'd4;  // 0x21..0x7E
    localparam logic [2:0] CS_BYTE  = 3'd5;  // every byte value

    // Number of characters in each charset. An illegal code uses size 1 so
    // the accumulator stays at zero.
    localparam logic [8:0] SIZE_LOWER   = 9'd26;
    localparam logic [8:0] SIZE_UPPER   = 9'd26;
    localparam logic [8:0] SIZE_ALPHA   = 9'd52;
    localparam logic [8:0] SIZE_ALNUM   = 9'd62;
    localparam logic [8:0] SIZE_PRINT   = 9'd94;
    localparam logic [8:0] SIZE_BYTE    = 9'd256;
    localparam logic [8:0] SIZE_ILLEGAL = 9'd1;

    // Range bounds of the character groups.
    localparam logic [7:0] CH_LOWER_FIRST = 8'h61;  // 'a'
    localparam logic [7:0] CH_LOWER_LAST  = 8'h7A;  // 'z'
    localparam logic [7:0] CH_UPPER_FIRST = 8'h41;  // 'A'
    localparam logic [7:0] CH_UPPER_LAST  = 8'h5A;  // 'Z'
    localparam logic [7:0] CH_DIGIT_FIRST = 8'h30;  // '0'
    localparam logic [7:0] CH_DIGIT_LAST  = 8'h39;  // '9'
    localparam logic [7:0] CH_PRINT_FIRST = 8'h21;  // '!'
    localparam logic [7:0] CH_PRINT_LAST  = 8'h7E;  // '~'

    // Offsets of the later groups inside the mixed charsets.
    localparam logic [7:0] OFS_UPPER_IN_ALPHA = 8'd26;
    localparam logic [7:0] OFS_DIGIT_IN_ALNUM = 8'd52;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Guess length field: 1..15 literal, 0 encodes 16.
    function automatic logic [4:0] decode_len(input logic [3:0] len);
        return (len == 4'd0) ? 5'd16 : {1'b0, len};
    endfunction

endpackage

// File: rtl/charset_reverse_lookup.sv
// Combinational reverse charset lookup.
//
// Purpose: map one ASCII byte to its position inside the selected charset.
// Ports:
//   charset  in   3   charset code (6 and 7 are illegal)
//   ascii    in   8   character to look up
//   pos      out  8   position of the character (0 when not found)
//   hit      out  1   character belongs to the charset
//   size     out  9   number of characters in the charset (1 when illegal)
module charset_reverse_lookup
    import guess_decoder_pkg::*;
(
    input  logic [2:0] charset,
    input  logic [7:0] ascii,
    output logic [7:0] pos,
    output logic       hit,
    output logic [8:0] size
);

    logic is_lower;
    logic is_upper;
    logic is_digit;
    logic is_print;

    assign is_lower = (ascii >= CH_LOWER_FIRST) && (ascii <= CH_LOWER_LAST);
    assign is_upper = (ascii >= CH_UPPER_FIRST) && (ascii <= CH_UPPER_LAST);
    assign is_digit = (ascii >= CH_DIGIT_FIRST) && (ascii <= CH_DIGIT_LAST);
    assign is_print = (ascii >= CH_PRINT_FIRST) && (ascii <= CH_PRINT_LAST);

    always_comb begin
        pos  = 8'd0;
        hit  = 1'b0;
        size = SIZE_ILLEGAL;
        case (charset)
            CS_LOWER: begin
                size = SIZE_LOWER;
                if (is_lower) begin
                    hit = 1'b1;
                    pos = ascii - CH_LOWER_FIRST;
                end
            end
            CS_UPPER: begin
                size = SIZE_UPPER;
                if (is_upper) begin
                    hit = 1'b1;
                    pos = ascii - CH_UPPER_FIRST;
                end
            end
            CS_ALPHA: begin
                size = SIZE_ALPHA;
                if (is_lower) begin
                    hit = 1'b1;
                    pos = ascii - CH_LOWER_FIRST;
                end else if (is_upper) begin
                    hit = 1'b1;
                    pos = ascii - CH_UPPER_FIRST + OFS_UPPER_IN_ALPHA;
                end
            end
            CS_ALNUM: begin
                size = SIZE_ALNUM;
                if (is_lower) begin
                    hit = 1'b1;
                    pos = ascii - CH_LOWER_FIRST;
                end else if (is_upper) begin
                    hit = 1'b1;
                    pos = ascii - CH_UPPER_FIRST + OFS_UPPER_IN_ALPHA;
                end else if (is_digit) begin
                    hit = 1'b1;
                    pos = ascii - CH_DIGIT_FIRST + OFS_DIGIT_IN_ALNUM;
                end
            end
            CS_PRINT: begin
                size = SIZE_PRINT;
                if (is_print) begin
                    hit = 1'b1;
                    pos = ascii - CH_PRINT_FIRST;
                end
            end
            CS_BYTE: begin
                size = SIZE_BYTE;
                hit  = 1'b1;
                pos  = ascii;
            end
            default: begin
                // Illegal code: no hit, size 1, position 0.
            end
        endcase
    end

endmodule

// File: rtl/guess_decoder.sv
// Guess decoder: turns an ASCII guess back into charset positions and the
// linear keyspace index (character 0 is the fastest-changing digit).
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; charset, guesslen, guess are
//                       sampled on the edge where both are high
//   charset  [2:0]      charset code 0..5
//   guesslen [3:0]      1..15, 0 means 16
//   guess    [127:0]    char i in bits [127-8i -: 8]
//   out_valid/out_ready result handshake
//   index    [INDEX_W-1:0] low INDEX_W bits of the keyspace index
//   digits   [127:0]    per-digit charset position, same layout as guess
//   overflow            true index needs more than INDEX_W bits
//   error               illegal charset or a character outside the charset
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in HOLD
// and, once raised, stays high with stable outputs until out_ready is seen;
// it drops on the edge that completes the transfer.
module guess_decoder
    import guess_decoder_pkg::*;
#(
    parameter int INDEX_W = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         charset,
    input  logic [3:0]         guesslen,
    input  logic [127:0]       guess,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INDEX_W-1:0] index,
    output logic [127:0]       digits,
    output logic               overflow,
    output logic               error
);

    // Accumulate step is INDEX_W x 9 bits plus an 8-bit position; the
    // top 9 bits of the sum are the carry-out used for overflow.
    localparam int PROD_W = INDEX_W + 9;

    state_e               state_q;
    logic [2:0]           cs_q;
    logic [127:0]         guess_q;
    logic [3:0]           k_q;
    logic [INDEX_W-1:0]   acc_q;
    logic [127:0]         digits_q;
    logic                 ovf_q;
    logic                 err_q;

    // Char k lives at bits [127-8k -: 8], i.e. byte slot (15-k) from the LSB.
    logic [3:0]           byte_slot;
    logic [6:0]           bit_lsb;
    logic [7:0]           cur_char;
    logic [7:0]           lk_pos;
    logic                 lk_hit;
    logic [8:0]           lk_size;
    logic [PROD_W-1:0]    mac;

    assign byte_slot = 4'd15 - k_q;
    assign bit_lsb   = {byte_slot, 3'b000};
    assign cur_char  = guess_q[bit_lsb +: 8];

    charset_reverse_lookup u_lookup (
        .charset (cs_q),
        .ascii   (cur_char),
        .pos     (lk_pos),
        .hit     (lk_hit),
        .size    (lk_size)
    );

    assign mac = PROD_W'(acc_q) * PROD_W'(lk_size) + PROD_W'(lk_pos);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cs_q     <= 3'd0;
            guess_q  <= 128'd0;
            k_q      <= 4'd0;
            acc_q    <= '0;
            digits_q <= 128'd0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        cs_q     <= charset;
                        guess_q  <= guess;
                        k_q      <= 4'(decode_len(guesslen) - 5'd1);
                        acc_q    <= '0;
                        digits_q <= 128'd0;
                        ovf_q    <= 1'b0;
                        err_q    <= 1'b0;
                        state_q  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Most significant digit first: acc = acc*size + pos.
                    digits_q[bit_lsb +: 8] <= lk_pos;
                    acc_q <= mac[INDEX_W-1:0];
                    if (|mac[PROD_W-1:INDEX_W]) begin
                        ovf_q <= 1'b1;
                    end
                    if (!lk_hit) begin
                        err_q <= 1'b1;
                    end
                    if (k_q == 4'd0) begin
                        state_q <= ST_HOLD;
                    end else begin
                        k_q <= k_q - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign index     = acc_q;
    assign digits    = digits_q;
    assign overflow  = ovf_q;
    assign error     = err_q;

endmodule

// File: tb/tb_guess_decoder.sv
// Bench for guess_decoder: directed cases plus random requests checked
// against a string-search reference model of the keyspace arithmetic.
module tb_guess_decoder;

    localparam int INDEX_W = 64;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [2:0]         charset = 3'd0;
    logic [3:0]         guesslen = 4'd0;
    logic [127:0]       guess = 128'd0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [INDEX_W-1:0] index;
    logic [127:0]       digits;
    logic               overflow;
    logic               error;

    int checks = 0;
    int errors = 0;

    string lower_s = "abcdefghijklmnopqrstuvwxyz";
    string upper_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string digit_s = "0123456789";

    guess_decoder #(.INDEX_W(INDEX_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .charset   (charset),
        .guesslen  (guesslen),
        .guess     (guess),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .index     (index),
        .digits    (digits),
        .overflow  (overflow),
        .error     (error)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int char_pos(input int cs, input logic [7:0] b);
        string s;
        case (cs)
            0: s = lower_s;
            1: s = upper_s;
            2: s = {lower_s, upper_s};
            3: s = {lower_s, upper_s, digit_s};
            4: return (b >= 8'h21 && b <= 8'h7E) ? int'(b) - 33 : -1;
            5: return int'(b);
            default: return -1;
        endcase
        for (int i = 0; i < s.len(); i++) begin
            if (8'(s[i]) == b) return i;
        end
        return -1;
    endfunction

    function automatic int cs_size(input int cs);
        case (cs)
            0, 1: return 26;
            2: return 52;
            3: return 62;
            4: return 94;
            5: return 256;
            default: return 1;
        endcase
    endfunction

    task automatic model(input logic [2:0] cs, input logic [3:0] gl, input logic [127:0] g,
                         output logic [63:0] idx, output logic [127:0] dg,
                         output logic ovf, output logic err, output int len);
        logic [139:0] v;
        v   = '0;
        dg  = '0;
        err = 1'b0;
        len = (gl == 4'd0) ? 16 : int'(gl);
        for (int k = len - 1; k >= 0; k--) begin
            int p;
            p = char_pos(int'(cs), g[127-8*k -: 8]);
            if (p < 0) begin
                err = 1'b1;
                p   = 0;
            end
            dg[127-8*k -: 8] = 8'(p);
            v = v * 140'(cs_size(int'(cs))) + 140'(p);
        end
        idx = v[63:0];
        ovf = |v[139:64];
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready),  128'd1);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_index"},     128'(index),     128'd0);
        chk({tag, "_digits"},    digits,          128'd0);
        chk({tag, "_overflow"},  128'(overflow),  128'd0);
        chk({tag, "_error"},     128'(error),     128'd0);
    endtask

    // Presents a request and returns #1 after the accepting edge.
    task automatic start_req(input string tag, input logic [2:0] cs, input logic [3:0] gl,
                             input logic [127:0] g);
        @(negedge clk);
        charset  = cs;
        guesslen = gl;
        guess    = g;
        in_valid = 1'b1;
        chk({tag, "_in_ready_before"}, 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge (edge 1) until out_valid, bounded.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_result(input string tag, input logic [2:0] cs, input logic [3:0] gl,
                                input logic [127:0] g, input int edges);
        logic [63:0]  e_idx;
        logic [127:0] e_dg;
        logic         e_ovf;
        logic         e_err;
        int           len;
        model(cs, gl, g, e_idx, e_dg, e_ovf, e_err, len);
        chk({tag, "_latency"},  128'(edges),     128'(len + 1));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd1);
        chk({tag, "_in_ready"}, 128'(in_ready),  128'd0);
        chk({tag, "_index"},    128'(index),     128'(e_idx));
        chk({tag, "_digits"},   digits,          e_dg);
        chk({tag, "_overflow"}, 128'(overflow),  128'(e_ovf));
        chk({tag, "_error"},    128'(error),     128'(e_err));
    endtask

    task automatic accept_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, 128'(out_valid), 128'd0);
        chk({tag, "_in_ready_back"},  128'(in_ready),  128'd1);
    endtask

    task automatic run_req(input string tag, input logic [2:0] cs, input logic [3:0] gl,
                           input logic [127:0] g);
        int e;
        start_req(tag, cs, gl, g);
        wait_valid(e);
        check_result(tag, cs, gl, g, e);
        accept_result(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] rg;
        logic [127:0] rg2;
        logic [2:0]   rcs;
        logic [3:0]   rgl;
        int           e;
        int           r;

        // Reset
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Lowercase "abc": index 0 + 1*26 + 2*676 = 1378
        rg = {"abc", 104'h0};
        start_req("abc", 3'd0, 4'd3, rg);
        wait_valid(e);
        check_result("abc", 3'd0, 4'd3, rg, e);
        chk("abc_const_latency", 128'(e), 128'd4);
        chk("abc_const_index", 128'(index), 128'd1378);
        chk("abc_const_digits", digits, {8'd0, 8'd1, 8'd2, 104'h0});
        accept_result("abc");

        // Alphanumeric "9": position 61
        rg = {"9", 120'h0};
        start_req("nine", 3'd3, 4'd1, rg);
        wait_valid(e);
        check_result("nine", 3'd3, 4'd1, rg, e);
        chk("nine_const_latency", 128'(e), 128'd2);
        chk("nine_const_index", 128'(index), 128'd61);
        chk("nine_const_digit0", 128'(digits[127:120]), 128'd61);
        accept_result("nine");

        // Overflow: 16 bytes of 0xFF in the byte charset
        rg = {128{1'b1}};
        start_req("ovf", 3'd5, 4'd0, rg);
        wait_valid(e);
        check_result("ovf", 3'd5, 4'd0, rg, e);
        chk("ovf_const_latency", 128'(e), 128'd17);
        chk("ovf_const_flag", 128'(overflow), 128'd1);
        chk("ovf_const_error", 128'(error), 128'd0);
        chk("ovf_const_index", 128'(index), 128'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf_const_digits", digits, {128{1'b1}});
        accept_result("ovf");

        // Invalid character in lowercase charset
        rg = {"aA", 112'h0};
        start_req("badch", 3'd0, 4'd2, rg);
        wait_valid(e);
        check_result("badch", 3'd0, 4'd2, rg, e);
        chk("badch_const_error", 128'(error), 128'd1);
        chk("badch_const_digit1", 128'(digits[119:112]), 128'd0);
        chk("badch_const_index", 128'(index), 128'd0);
        accept_result("badch");

        // Illegal charset code
        rg = {"abc", 104'h0};
        start_req("badcs", 3'd6, 4'd3, rg);
        wait_valid(e);
        check_result("badcs", 3'd6, 4'd3, rg, e);
        chk("badcs_const_error", 128'(error), 128'd1);
        chk("badcs_const_index", 128'(index), 128'd0);
        accept_result("badcs");

        // Backpressure: hold the result 5 cycles while a second request waits
        rg  = {"abc", 104'h0};
        rg2 = {"zZaB", 96'h0};
        start_req("bp1", 3'd0, 4'd3, rg);
        wait_valid(e);
        check_result("bp1", 3'd0, 4'd3, rg, e);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            charset  = 3'd2;
            guesslen = 4'd4;
            guess    = rg2;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_hold_out_valid", 128'(out_valid), 128'd1);
            chk("bp_hold_in_ready", 128'(in_ready), 128'd0);
            chk("bp_hold_index", 128'(index), 128'd1378);
            chk("bp_hold_digits", digits, {8'd0, 8'd1, 8'd2, 104'h0});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp2_accepted", 128'(in_ready), 128'd0);
        wait_valid(e);
        check_result("bp2", 3'd2, 4'd4, rg2, e);
        accept_result("bp2");

        // Mid-decode asynchronous reset
        rg = {"zzzzzzzzzz", 48'h0};
        start_req("midrst", 3'd0, 4'd10, rg);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        rg = {"abc", 104'h0};
        start_req("postrst", 3'd0, 4'd3, rg);
        wait_valid(e);
        check_result("postrst", 3'd0, 4'd3, rg, e);
        chk("postrst_const_index", 128'(index), 128'd1378);
        accept_result("postrst");

        // Random requests; bytes beyond the length are random junk
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 9) == 0) rcs = 3'($urandom_range(6, 7));
            else rcs = 3'($urandom_range(0, 5));
            rgl = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 3)      rg[127-8*i -: 8] = 8'($urandom_range(8'h61, 8'h7A));
                else if (r < 6) rg[127-8*i -: 8] = 8'($urandom_range(8'h41, 8'h5A));
                else if (r < 8) rg[127-8*i -: 8] = 8'($urandom_range(8'h30, 8'h39));
                else if (r < 9) rg[127-8*i -: 8] = 8'($urandom_range(8'h21, 8'h7E));
                else            rg[127-8*i -: 8] = 8'($urandom_range(0, 255));
            end
            run_req("rand", rcs, rgl, rg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
